demux_stream_1ton: RTL and testbench
====================================

Name: demux_stream_1toN

Overview:
- Parametrised successor to the combinational 1:2 demux: a registered 1-to-N stream demultiplexer with valid/ready handshake on the input and on every output channel.
- A word presented with a channel select is captured into that channel's one-entry output register. Each channel drains independently.
- Sits between a single producer and N consumer lanes. Supports back-pressure per lane without stalling traffic to other lanes.

Parameters:
- WIDTH, 8, data width in bits per word.
- N, 4, number of output channels (1..256).
- SEL_W is a derived localparam, not a parameter: SEL_W = (N > 1) ? $clog2(N) : 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  N  bit k: channel k register holds a word.
- out_ready  input  N  bit k: consumer k takes the word this cycle.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- drop_err  output  1  one-cycle pulse: a word with out-of-range select was dropped.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid = 0, out_data = 0, drop_err = 0.
  - All channel registers are emptied.
  - Reset asserted mid-transfer discards all held words. There is no partial state.
- Per channel k, full[k] = out_valid[k].
- in_ready is combinational:
  - in_sel >= N: in_ready = 1.
  - Otherwise: in_ready = !full[in_sel] || out_ready[in_sel].
  - in_ready never depends on in_valid.
- Accept: in_valid && in_ready at a rising edge.
- Latency: an accepted word appears on the out_data slice of channel in_sel with out_valid set on the next cycle. The latency is exactly 1 cycle.
- Drain: out_valid[k] && out_ready[k] at an edge empties channel k, unless the same edge refills it.
- Simultaneous drain and fill on the same channel: the channel stays full with the new word. This sustains full throughput, 1 word/cycle.
- Stall: while out_valid[k] && !out_ready[k], out_data slice k and out_valid[k] hold stable.
- Channels are independent. Back-pressure on channel j does not block accepts to channel k != j.
- Out-of-range select (in_sel >= N, possible when N is not a power of 2, or N = 1 with sel = 1):
  - The word is accepted and discarded.
  - No out_valid changes.
  - drop_err is high for exactly the next cycle.
- drop_err is registered. Back-to-back drops keep it high continuously.
- out_ready[k] while out_valid[k] = 0: ignored.
- in_data and in_sel are don't-care when in_valid = 0. No state changes.
- Only one channel is written per cycle. Any number of channels may drain in the same cycle.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Extra output port xfer_cnt, N*8 bits.
  - Channel k holds an 8-bit saturating count of completed output handshakes (out_valid[k] && out_ready[k]).
  - The count increments on the edge of each handshake and saturates at 255 (no wrap).
  - Reset value is 0.
  - Additional input stats_clr, 1 bit: synchronous clear of all counters. Clear wins over a simultaneous increment.
- Not defined:
  - Ports xfer_cnt and stats_clr do not exist.
  - No counter logic. All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 applied mid-stream with channel 2 holding 8'hA5 -> out_valid=4'b0000, out_data=0 and drop_err=0 immediately, before any clock edge.
- Basic route: N=4, in_data=8'h3C, in_sel=2, in_valid=1, out_ready=4'b1111 -> next cycle out_valid=4'b0100, out_data[23:16]=8'h3C; in_ready stayed 1.
- Back-pressure: fill channel 1 with 8'h11, out_ready[1]=0, send 8'h22 to sel=1 -> in_ready=0; the word 8'h22 is held by the producer. Send 8'h33 to sel=0 -> accepted, out_valid=4'b0011. Raise out_ready[1] -> 8'h22 accepted in the same cycle, channel 1 shows 8'h22 next cycle.
- Full throughput: stream 16 words 0..15 to sel=3 with out_ready[3]=1 -> one word per cycle, out_data[31:24] sequence 0..15 with 1-cycle delay, no gaps.
- Out-of-range: N=3, in_sel=3, in_valid=1 -> in_ready=1, next cycle drop_err=1 for one cycle, out_valid unchanged.
- DEMUX_STATS_EN: 300 handshakes on channel 0 -> xfer_cnt[7:0]=255. Pulse stats_clr -> 0 next cycle. Other channel counts unaffected by channel 0 traffic.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// -----------------------------------------------------------------------------
// demux_stream_1ton
//
// Registered 1-to-N stream demultiplexer. A word accepted on the input
// handshake is written into the one-entry output register of the channel
// named by in_sel and shows up there one cycle later. Each channel drains on
// its own valid/ready handshake, so a stalled consumer only blocks traffic
// aimed at its own lane. A word whose select names no channel is accepted,
// discarded and flagged with a one-cycle drop_err pulse.
//
// Parameters:
//   WIDTH  data width in bits per word
//   N      number of output channels (1..256)
//   SEL_W  derived select width, (N > 1) ? $clog2(N) : 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word
//   in_ready   block accepts the word this cycle (combinational)
//   in_data    input word
//   in_sel     destination channel index
//   out_valid  bit k: channel k register holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   out_data   channel k occupies bits [k*WIDTH +: WIDTH]
//   drop_err   registered pulse: an out-of-range word was dropped
//
// Optional build macro DEMUX_STATS_EN adds:
//   stats_clr  synchronous clear of all transfer counters (wins over count)
//   xfer_cnt   channel k holds an 8-bit saturating count of output
//              handshakes in bits [k*8 +: 8]
// -----------------------------------------------------------------------------
module demux_stream_1ton #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               drop_err
`ifdef DEMUX_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [N*8-1:0]     xfer_cnt
`endif
);

  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0][WIDTH-1:0] data_q,  data_d;
  logic                    drop_q,  drop_d;

  logic                    sel_in_range;
  logic                    sel_ready;
  logic                    accept;

  // Decode the select by comparing against every channel index instead of
  // indexing valid_q[in_sel]: an out-of-range select then simply matches
  // nothing and never produces an out-of-bounds access.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_in_range = 1'b0;
    sel_ready    = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_in_range = 1'b1;
        sel_ready    = !valid_q[k] || out_ready[k];
      end
    end
  end

  // Out-of-range words are always taken so the producer never deadlocks.
  assign in_ready = sel_ready;
  assign accept   = in_valid && in_ready;

  // Drain first, then let a same-cycle fill override it: a channel that is
  // emptied and refilled on one edge stays full with the new word.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < N; k++) begin
      if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
      if (accept && (in_sel == SEL_W'(k))) begin
        valid_d[k] = 1'b1;
        data_d[k]  = in_data;
      end
    end
    drop_d = accept && !sel_in_range;
  end

  // NOTE: the data registers are reset as well as the valid bits because
  // out_data must read zero straight out of reset.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_err  = drop_q;

`ifdef DEMUX_STATS_EN
  logic [N-1:0][7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N; k++) begin
      if (stats_clr) begin
        cnt_d[k] = 8'd0;
      end else if (valid_q[k] && out_ready[k] && (cnt_q[k] != 8'hFF)) begin
        cnt_d[k] = cnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_demux_stream_1ton.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_1ton
//
// Self-checking bench for demux_stream_1ton. A four-channel instance carries
// the routing, back-pressure, reset and throughput stimulus; a three-channel
// instance covers the out-of-range select. Every accepted word is pushed
// into a per-channel expected queue; a monitor on the falling edge pops and
// compares whenever a channel completes an output handshake.
// -----------------------------------------------------------------------------
module tb_demux_stream_1ton;

  logic        clk;
  logic        rst_n;

  // Four-channel instance
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        drop_err;

  // Three-channel instance
  logic        in_valid3;
  logic        in_ready3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic [23:0] out_data3;
  logic        drop3;

`ifdef DEMUX_STATS_EN
  logic        stats_clr;
  logic [31:0] xfer_cnt;
  logic        stats_clr3;
  logic [23:0] xfer_cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q [4][$];

  demux_stream_1ton #(.WIDTH(8), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .drop_err  (drop_err)
`ifdef DEMUX_STATS_EN
    ,
    .stats_clr (stats_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  demux_stream_1ton #(.WIDTH(8), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .drop_err  (drop3)
`ifdef DEMUX_STATS_EN
    ,
    .stats_clr (stats_clr3),
    .xfer_cnt  (xfer_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the
  // falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor: a handshake visible at the falling edge completes on
  // the next rising edge, so the word on the bus now is the one consumed.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sb_q[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected ch%0d actual=%0h required=nothing", k, out_data[k*8 +: 8]);
          end else begin
            check($sformatf("sb_ch%0d", k), 64'(out_data[k*8 +: 8]), 64'(sb_q[k].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_sel     = '0;
    out_ready  = '0;
    in_valid3  = 1'b0;
    in_data3   = '0;
    in_sel3    = '0;
    out_ready3 = '0;
`ifdef DEMUX_STATS_EN
    stats_clr  = 1'b0;
    stats_clr3 = 1'b0;
`endif

    // ---- Reset state ----
    #3;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_drop_err",  64'(drop_err),  64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h1);
    #20 rst_n = 1'b1;

    // ---- Basic route: 3C to channel 2 ----
    step();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    in_sel    = 2'd2;
    sample();
    check("route_in_ready", 64'(in_ready), 64'h1);
    sb_q[2].push_back(8'h3C);
    step();
    in_valid = 1'b0;
    sample();
    check("route_out_valid", 64'(out_valid), 64'h4);
    check("route_out_data",  64'(out_data[23:16]), 64'h3C);
    step();
    out_ready = 4'b0000;
    sample();
    check("route_drained", 64'(out_valid), 64'h0);

    // ---- Back-pressure on channel 1, channel 0 stays open ----
    step();
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_sel   = 2'd1;
    sample();
    check("bp_fill_ready", 64'(in_ready), 64'h1);
    sb_q[1].push_back(8'h11);
    step();
    in_data = 8'h22;
    sample();
    check("bp_blocked_ready", 64'(in_ready), 64'h0);
    check("bp_blocked_valid", 64'(out_valid), 64'h2);
    step();
    in_data = 8'h33;
    in_sel  = 2'd0;
    sample();
    check("bp_other_ready", 64'(in_ready), 64'h1);
    sb_q[0].push_back(8'h33);
    step();
    in_data   = 8'h22;
    in_sel    = 2'd1;
    out_ready = 4'b0010;
    sample();
    check("bp_both_full", 64'(out_valid), 64'h3);
    check("bp_drain_fill_ready", 64'(in_ready), 64'h1);
    sb_q[1].push_back(8'h22);
    step();
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    sample();
    check("bp_still_full", 64'(out_valid), 64'h3);
    check("bp_ch1_data", 64'(out_data[15:8]), 64'h22);
    check("bp_ch0_data", 64'(out_data[7:0]),  64'h33);

    // ---- Reset mid-stream with channel 2 holding A5 ----
    step();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_sel   = 2'd2;
    sample();
    check("mid_fill_ready", 64'(in_ready), 64'h1);
    step();
    in_valid = 1'b0;
    sample();
    check("mid_ch2_data", 64'(out_data[23:16]), 64'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_data",  64'(out_data),  64'h0);
    check("mid_rst_drop",  64'(drop_err),  64'h0);
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    #3 rst_n = 1'b1;

    // ---- Full throughput: 0..15 to channel 3 ----
    step();
    out_ready = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_sel   = 2'd3;
      sample();
      check($sformatf("tp_ready_%0d", i), 64'(in_ready), 64'h1);
      sb_q[3].push_back(8'(i));
      if (i > 0) begin
        check($sformatf("tp_data_%0d", i - 1), 64'(out_data[31:24]), 64'(i - 1));
        check($sformatf("tp_valid_%0d", i - 1), 64'(out_valid), 64'h8);
      end
      step();
    end
    in_valid = 1'b0;
    sample();
    check("tp_data_15",  64'(out_data[31:24]), 64'hF);
    check("tp_valid_15", 64'(out_valid), 64'h8);
    step();
    sample();
    check("tp_empty", 64'(out_valid), 64'h0);

    // ---- Out-of-range select on the three-channel instance ----
    step();
    in_valid3 = 1'b1;
    in_data3  = 8'h77;
    in_sel3   = 2'd2;
    sample();
    check("oor_fill_ready", 64'(in_ready3), 64'h1);
    step();
    in_data3 = 8'hEE;
    in_sel3  = 2'd3;
    sample();
    check("oor_ready", 64'(in_ready3), 64'h1);
    check("oor_no_drop_yet", 64'(drop3), 64'h0);
    check("oor_valid_before", 64'(out_valid3), 64'h4);
    step();
    sample();
    check("oor_drop_1", 64'(drop3), 64'h1);
    check("oor_valid_after", 64'(out_valid3), 64'h4);
    step();
    in_valid3 = 1'b0;
    sample();
    check("oor_drop_2", 64'(drop3), 64'h1);
    step();
    sample();
    check("oor_drop_clear", 64'(drop3), 64'h0);
    check("oor_valid_final", 64'(out_valid3), 64'h4);
    check("oor_data_kept", 64'(out_data3[23:16]), 64'h77);
    check("n4_no_drop", 64'(drop_err), 64'h0);

`ifdef DEMUX_STATS_EN
    // ---- Statistics: 300 handshakes on channel 0 saturate at 255 ----
    step();
    out_ready = 4'b0001;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_sel   = 2'd0;
      sample();
      sb_q[0].push_back(8'(i));
      step();
    end
    in_valid = 1'b0;
    sample();
    step();
    sample();
    check("stats_ch0_sat", 64'(xfer_cnt[7:0]),   64'd255);
    check("stats_ch1",     64'(xfer_cnt[15:8]),  64'd0);
    check("stats_ch2",     64'(xfer_cnt[23:16]), 64'd0);
    check("stats_ch3",     64'(xfer_cnt[31:24]), 64'd16);
    // Clear coincides with a channel 0 handshake: clear must win.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    in_sel   = 2'd0;
    sample();
    sb_q[0].push_back(8'h5A);
    step();
    in_valid  = 1'b0;
    stats_clr = 1'b1;
    sample();
    step();
    stats_clr = 1'b0;
    sample();
    check("stats_clr", 64'(xfer_cnt), 64'h0);
`endif

    // ---- Final drain: nothing left over ----
    step();
    out_ready = 4'b1111;
    in_valid  = 1'b0;
    step();
    step();
    sample();
    check("final_empty", 64'(out_valid), 64'h0);
    check("final_sb_empty",
          64'(sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
